sprite_cmd_encoder: RTL and testbench

Host-side transmitter for the display command bus consumed by the sprite display components (Bowser, Mario, etc.). It holds a table of sprite descriptors written by the host. On each frame_start it serialises the table into 32-bit command words: per-field updates into the back buffer, then one commit word per sprite. The block sits between the Avalon host slave and the broadcast writedata bus that feeds all display components.

---
 rtl/disp_cmd_pkg.sv | 78 +++++++
 rtl/cmd_out_reg.sv | 42 ++++
 rtl/sprite_cmd_encoder.sv | 177 +++++++++++++++++
 tb/tb_sprite_cmd_encoder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_cmd_pkg.sv
// Shared definitions for the sprite display command bus.
// Imported by the encoder and by every receiving display component.
package disp_cmd_pkg;

    localparam int CMD_COMP_LSB   = 26;
    localparam int CMD_CHILD_LSB  = 21;
    localparam int CMD_ACT_LSB    = 17;
    localparam int CMD_ATYPE_LSB  = 14;
    localparam int CMD_TOGGLE_BIT = 13;

    localparam logic [3:0] ACT_UPDATE = 4'b0001;
    localparam logic [3:0] ACT_COMMIT = 4'b1111;

    localparam logic [2:0] ATYPE_COMMIT = 3'b000;
    localparam logic [2:0] ATYPE_VIS    = 3'b001;
    localparam logic [2:0] ATYPE_X      = 3'b010;
    localparam logic [2:0] ATYPE_Y      = 3'b011;
    localparam logic [2:0] ATYPE_ATTR   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_UPD,
        ST_CSCAN,
        ST_DONE
    } enc_state_t;

    typedef struct packed {
        logic       enable;
        logic [5:0] comp_id;
        logic [4:0] child;
        logic       visible;
        logic       flip;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] attr;
    } sprite_desc_t;

    function automatic logic [31:0] pack_cmd(
        input logic [5:0]  comp,
        input logic [4:0]  child,
        input logic [3:0]  action,
        input logic [2:0]  atype,
        input logic        toggle,
        input logic [12:0] data
    );
        logic [31:0] w;
        w                      = '0;
        w[CMD_COMP_LSB +: 6]   = comp;
        w[CMD_CHILD_LSB +: 5]  = child;
        w[CMD_ACT_LSB +: 4]    = action;
        w[CMD_ATYPE_LSB +: 3]  = atype;
        w[CMD_TOGGLE_BIT]      = toggle;
        w[12:0]                = data;
        return w;
    endfunction

    // A disabled descriptor yields an empty payload.
    function automatic logic [31:0] update_word(
        input sprite_desc_t d,
        input logic [2:0]   atype,
        input logic         toggle
    );
        logic [12:0] data;
        data = '0;
        if (d.enable) begin
            case (atype)
                ATYPE_VIS:  data = {d.visible, d.flip, 11'd0};
                ATYPE_X:    data = {3'd0, d.x};
                ATYPE_Y:    data = {3'd0, d.y};
                ATYPE_ATTR: data = {3'd0, d.attr};
                default:    data = '0;
            endcase
        end
        return pack_cmd(d.comp_id, d.child, ACT_UPDATE, atype, toggle, data);
    endfunction

endpackage

// File: rtl/cmd_out_reg.sv
// Single-entry valid/ready output register; the held word stays stable
// until the downstream accepts it.
module cmd_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/sprite_cmd_encoder.sv
// Sprite descriptor table plus frame walker that serialises per-field
// back-buffer updates followed by one commit per enabled sprite.
module sprite_cmd_encoder
    import disp_cmd_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_write,
    input  logic [IDX_W:0]   host_addr,
    input  logic [31:0]      host_writedata,
    input  logic             frame_start,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [31:0]      cmd_writedata,
    output logic             busy,
    output logic             frame_done,
    output logic             front_buffer,
    output logic             overrun
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    enc_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       k_q, k_d;
    logic             any_sent_q, any_sent_d;
    logic             front_q, front_d;
    logic             overrun_q, overrun_d;
    sprite_desc_t     snap_q, snap_d;
    sprite_desc_t     table_q [NUM_ENTRIES];
    sprite_desc_t     cur;
    logic             back;
    logic             push_valid, push_ready;
    logic [31:0]      push_data;

    assign cur  = table_q[idx_q];
    assign back = ~front_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            sprite_desc_t entry_d;
            always_comb begin
                entry_d = table_q[gi];
                if (host_write && host_addr[IDX_W:1] == IDX_W'(gi)) begin
                    if (!host_addr[0]) begin
                        entry_d.enable  = host_writedata[31];
                        entry_d.comp_id = host_writedata[30:25];
                        entry_d.child   = host_writedata[24:20];
                        entry_d.visible = host_writedata[19];
                        entry_d.flip    = host_writedata[18];
                    end else begin
                        entry_d.x    = host_writedata[29:20];
                        entry_d.y    = host_writedata[19:10];
                        entry_d.attr = host_writedata[9:0];
                    end
                end
            end
            always_ff @(posedge clk) begin
                if (reset) table_q[gi] <= '0;
                else       table_q[gi] <= entry_d;
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        k_d        = k_q;
        any_sent_d = any_sent_q;
        snap_d     = snap_q;
        front_d    = front_q;
        push_valid = 1'b0;
        push_data  = '0;
        overrun_d  = overrun_q | (frame_start && state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_SCAN;
                    idx_d      = '0;
                    any_sent_d = 1'b0;
                end
            end
            // The visibility word is pushed straight from the table in the
            // same cycle the snapshot is taken, so both carry identical data.
            ST_SCAN: begin
                if (cur.enable) begin
                    push_valid = 1'b1;
                    push_data  = update_word(cur, ATYPE_VIS, back);
                    if (push_ready) begin
                        snap_d  = cur;
                        k_d     = 2'd1;
                        state_d = ST_UPD;
                    end
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_CSCAN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            // k = 1,2,3 maps onto the x, y, attr action types (2,3,4).
            ST_UPD: begin
                push_valid = 1'b1;
                push_data  = update_word(snap_q, 3'(k_q) + 3'd1, back);
                if (push_ready) begin
                    if (k_q == 2'd3) begin
                        any_sent_d = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_CSCAN;
                            idx_d   = '0;
                        end else begin
                            state_d = ST_SCAN;
                            idx_d   = idx_q + 1'b1;
                        end
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            ST_CSCAN: begin
                if (cur.enable) begin
                    push_valid = 1'b1;
                    push_data  = pack_cmd(cur.comp_id, cur.child, ACT_COMMIT,
                                          ATYPE_COMMIT, back, 13'd0);
                end
                if (!cur.enable || push_ready) begin
                    if (idx_q == LAST_IDX) state_d = ST_DONE;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (any_sent_q) front_d = back;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            k_q        <= '0;
            any_sent_q <= 1'b0;
            front_q    <= 1'b0;
            overrun_q  <= 1'b0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            any_sent_q <= any_sent_d;
            front_q    <= front_d;
            overrun_q  <= overrun_d;
            snap_q     <= snap_d;
        end
    end

    cmd_out_reg #(.W(32)) u_out (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push_valid),
        .in_data   (push_data),
        .in_ready  (push_ready),
        .out_valid (cmd_valid),
        .out_data  (cmd_writedata),
        .out_ready (cmd_ready)
    );

    assign busy         = (state_q != ST_IDLE);
    assign frame_done   = (state_q == ST_DONE);
    assign front_buffer = front_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Self-checking bench: table-driven frames, directed corner sequences and
// randomized frames checked against a word-list reference model.
module tb_sprite_cmd_encoder;
    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          host_write = 1'b0;
    logic [IW:0]   host_addr = '0;
    logic [31:0]   host_writedata = '0;
    logic          frame_start = 1'b0;
    logic          cmd_ready = 1'b1;
    logic          cmd_valid;
    logic [31:0]   cmd_writedata;
    logic          busy, frame_done, front_buffer, overrun;

    sprite_cmd_encoder #(.NUM_ENTRIES(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .host_write     (host_write),
        .host_addr      (host_addr),
        .host_writedata (host_writedata),
        .frame_start    (frame_start),
        .cmd_ready      (cmd_ready),
        .cmd_valid      (cmd_valid),
        .cmd_writedata  (cmd_writedata),
        .busy           (busy),
        .frame_done     (frame_done),
        .front_buffer   (front_buffer),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: descriptor table and committed buffer index.
    logic       m_en [N];
    logic [5:0] m_comp [N];
    logic [4:0] m_child [N];
    logic       m_vis [N];
    logic       m_flip [N];
    logic [9:0] m_x [N];
    logic [9:0] m_y [N];
    logic [9:0] m_attr [N];
    logic       m_front = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    function automatic logic [31:0] mk(input int comp, input int child, input int act,
                                       input int at, input int tog, input int data);
        return 32'((comp << 26) | (child << 21) | (act << 17) | (at << 14) | (tog << 13) | data);
    endfunction

    task automatic build_expected();
        int tog;
        tog = m_front ? 0 : 1;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            if (m_en[i]) begin
                exp_q.push_back(mk(m_comp[i], m_child[i], 1, 1, tog,
                                   (int'(m_vis[i]) << 12) | (int'(m_flip[i]) << 11)));
                exp_q.push_back(mk(m_comp[i], m_child[i], 1, 2, tog, int'(m_x[i])));
                exp_q.push_back(mk(m_comp[i], m_child[i], 1, 3, tog, int'(m_y[i])));
                exp_q.push_back(mk(m_comp[i], m_child[i], 1, 4, tog, int'(m_attr[i])));
            end
        end
        for (int i = 0; i < N; i++)
            if (m_en[i]) exp_q.push_back(mk(m_comp[i], m_child[i], 15, 0, tog, 0));
    endtask

    task automatic rand_entry(input int i, input logic en);
        m_en[i]    = en;
        m_comp[i]  = 6'($urandom);
        m_child[i] = 5'($urandom);
        m_vis[i]   = 1'($urandom);
        m_flip[i]  = 1'($urandom);
        m_x[i]     = 10'($urandom);
        m_y[i]     = 10'($urandom);
        m_attr[i]  = 10'($urandom);
    endtask

    task automatic plan_entry0();
        m_en[0] = 1'b1; m_comp[0] = 6'b001001; m_child[0] = 5'd0;
        m_vis[0] = 1'b1; m_flip[0] = 1'b0;
        m_x[0] = 10'd100; m_y[0] = 10'd200; m_attr[0] = 10'd5;
    endtask

    task automatic host_wr(input int idx, input logic wsel, input logic [31:0] data);
        host_write = 1'b1;
        host_addr = {3'(idx), wsel};
        host_writedata = data;
        @(posedge clk); #1;
        host_write = 1'b0;
    endtask

    task automatic load_entry(input int i);
        host_wr(i, 1'b0, {m_en[i], m_comp[i], m_child[i], m_vis[i], m_flip[i], 18'($urandom)});
        host_wr(i, 1'b1, {2'($urandom), m_x[i], m_y[i], m_attr[i]});
    endtask

    task automatic load_all();
        for (int i = 0; i < N; i++) load_entry(i);
    endtask

    // Ready pattern: 0 = always high, 1 = toggling, 2 = random.
    int ready_mode = 0;
    always @(posedge clk) begin
        #2;
        if (ready_mode == 0)      cmd_ready = 1'b1;
        else if (ready_mode == 1) cmd_ready = ~cmd_ready;
        else                      cmd_ready = 1'($urandom);
    end

    // Transfer capture and backpressure stability check.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    int          done_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_hold) begin
                check("hold_valid", {31'd0, cmd_valid}, 32'd1);
                check("hold_data", cmd_writedata, prev_data);
            end
            if (cmd_valid && cmd_ready) got_q.push_back(cmd_writedata);
            if (frame_done) done_cnt++;
        end
        prev_hold = !reset && cmd_valid && !cmd_ready;
        prev_data = cmd_writedata;
    end

    task automatic run_frame(input string tag, input bit lat, input int extra_at);
        int seen;
        int cyc;
        int d;
        build_expected();
        got_q.delete();
        seen = done_cnt;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        cyc = 0;
        if (lat) begin
            check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
            check({tag, " valid_at_plus1"}, {31'd0, cmd_valid}, 32'd0);
            @(posedge clk); #1;
            cyc = 1;
            check({tag, " valid_at_plus2"}, {31'd0, cmd_valid}, 32'd1);
            if (exp_q.size() > 0) check({tag, " first_word"}, cmd_writedata, exp_q[0]);
        end
        while (done_cnt == seen && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == extra_at) begin
                frame_start = 1'b1;
                @(posedge clk); #1;
                frame_start = 1'b0;
                cyc++;
            end
        end
        check({tag, " done_in_time"}, {31'd0, (cyc < 2000)}, 32'd1);
        d = 0;
        while (cmd_valid && d < 100) begin
            @(posedge clk); #1;
            d++;
        end
        check({tag, " drained"}, {31'd0, cmd_valid}, 32'd0);
        check({tag, " done_pulses"}, 32'(done_cnt - seen), 32'd1);
        check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s word%0d", tag, i), got_q[i], exp_q[i]);
        if (exp_q.size() != 0) m_front = ~m_front;
        check({tag, " front"}, {31'd0, front_buffer}, {31'd0, m_front});
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] en_mask;
        int         rdy;
        int         exp_words;
        logic       exp_flip;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic front_before;
        logic [7:0] mask;

        vecs[0] = '{8'h01, 0, 5, 1'b1};
        vecs[1] = '{8'h01, 0, 5, 1'b1};
        vecs[2] = '{8'h21, 1, 10, 1'b1};
        vecs[3] = '{8'h00, 0, 0, 1'b0};
        vecs[4] = '{8'h80, 2, 5, 1'b1};
        vecs[5] = '{8'hFF, 2, 40, 1'b1};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("reset cmd_writedata", cmd_writedata, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);
        check("reset front", {31'd0, front_buffer}, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < N; i++) rand_entry(i, vecs[v].en_mask[i]);
            if (v < 2) plan_entry0();
            load_all();
            ready_mode = vecs[v].rdy;
            front_before = m_front;
            run_frame($sformatf("vec%0d", v), (v == 0), 0);
            check($sformatf("vec%0d table_words", v), 32'(got_q.size()), 32'(vecs[v].exp_words));
            check($sformatf("vec%0d table_flip", v), {31'd0, front_buffer ^ front_before},
                  {31'd0, vecs[v].exp_flip});
        end
        check("no overrun yet", {31'd0, overrun}, 32'd0);

        // frame_start re-pulsed mid-walk
        for (int i = 0; i < N; i++) rand_entry(i, (i < 4));
        load_all();
        ready_mode = 1;
        run_frame("overrun_walk", 1'b0, 5);
        check("overrun set", {31'd0, overrun}, 32'd1);
        ready_mode = 0;
        run_frame("overrun_next", 1'b0, 0);
        check("overrun sticky", {31'd0, overrun}, 32'd1);

        // reset during the third update word
        for (int i = 0; i < N; i++) rand_entry(i, 1'b0);
        plan_entry0();
        load_all();
        ready_mode = 0;
        @(posedge clk); #1;
        build_expected();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst third word", cmd_writedata, exp_q[2]);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst cmd_valid", {31'd0, cmd_valid}, 32'd0);
        reset = 1'b0;
        check("rst cmd_writedata", cmd_writedata, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst frame_done", {31'd0, frame_done}, 32'd0);
        check("rst front", {31'd0, front_buffer}, 32'd0);
        check("rst overrun", {31'd0, overrun}, 32'd0);
        m_front = 1'b0;
        for (int i = 0; i < N; i++) m_en[i] = 1'b0;
        run_frame("post_rst_empty", 1'b0, 0);
        plan_entry0();
        load_entry(0);
        run_frame("post_rst_frame", 1'b1, 0);
        if (got_q.size() > 0)
            check("post_rst toggle", {31'd0, got_q[0][13]}, 32'd1);

        // randomized frames
        for (int r = 0; r < 8; r++) begin
            mask = 8'($urandom);
            for (int i = 0; i < N; i++) rand_entry(i, mask[i]);
            load_all();
            ready_mode = $urandom_range(0, 2);
            run_frame($sformatf("rand%0d", r), 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
